// File: rtl/button_conditioner.sv
// Confirm-button and mode-switch front end: 2-flop sync, debounce, press/long-press pulses, stable mode_sel.
// Optional long-press detection is compiled in when LONG_PRESS_EN is defined; otherwise long_pulse is tied 0.
module button_conditioner #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic [3:0] sw_raw,
    output logic       btn_pulse,
    output logic       btn_level,
    output logic [3:0] mode_sel,
    output logic       mode_valid,
    output logic [3:0] mode_at_press,
    output logic       long_pulse
);
    localparam int DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYCLES = CLK_HZ / 1000 * LONG_MS;
    localparam int MAX_CYCLES  = (DB_CYCLES > LONG_CYCLES) ? DB_CYCLES : LONG_CYCLES;
    localparam int CW          = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    function automatic logic valid_mode(input logic [3:0] m);
        case (m)
            4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111: valid_mode = 1'b1;
            default:                                     valid_mode = 1'b0;
        endcase
    endfunction

    logic       btn_m, btn_s;
    logic [3:0] sw_m, sw_s;
    logic [1:0] sync_fill;
    logic       armed;

    // sync_fill marks when btn_s carries real pin data rather than the reset fill,
    // so a button held through reset is never mistaken for a release.
    // NOTE: every clocked block uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m     <= 1'b0;
            btn_s     <= 1'b0;
            sw_m      <= 4'd0;
            sw_s      <= 4'd0;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            btn_m     <= btn_raw;
            btn_s     <= btn_m;
            sw_m      <= sw_raw;
            sw_s      <= sw_m;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && !btn_s) armed <= 1'b1;
        end
    end

    btn_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          press_evt;
    logic          pulse_pend;

`ifdef LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_CNT  = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    logic long_evt, long_done, long_pend;
`endif

    // NOTE: all always_comb outputs take a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_evt = 1'b0;
`ifdef LONG_PRESS_EN
        long_evt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (btn_s && armed) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                    press_evt = 1'b1;
`ifdef LONG_PRESS_EN
                    cnt_nxt   = cnt + 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
`ifdef LONG_PRESS_EN
                else if (cnt < LONG_CNT) begin
                    cnt_nxt  = cnt + 1'b1;
                    long_evt = (cnt == LONG_LAST) && !long_done;
                end
`endif
            end
            RELEASE_WAIT: begin
                // A release bounce returns to HELD without a new press event.
                if (btn_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            pulse_pend    <= 1'b0;
            btn_pulse     <= 1'b0;
            btn_level     <= 1'b0;
            mode_at_press <= 4'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pulse_pend <= press_evt;
            btn_pulse  <= pulse_pend;
            btn_level  <= (state == HELD) || (state == RELEASE_WAIT);
            // Captures the pre-update mode_sel when a switch change lands in the same cycle.
            if (pulse_pend) mode_at_press <= mode_sel;
        end
    end

`ifdef LONG_PRESS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_done  <= 1'b0;
            long_pend  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pend  <= long_evt;
            long_pulse <= long_pend;
            if (long_evt) long_done <= 1'b1;
            else if (state == IDLE) long_done <= 1'b0;
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

    logic [3:0]    sw_cand;
    logic [CW-1:0] swc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_cand    <= 4'd0;
            swc        <= '0;
            mode_sel   <= 4'd0;
            mode_valid <= 1'b0;
        end else if (sw_s != sw_cand) begin
            sw_cand <= sw_s;
            swc     <= '0;
        end else if (swc != DB_LAST) begin
            swc <= swc + 1'b1;
        end else begin
            mode_sel   <= sw_cand;
            mode_valid <= valid_mode(sw_cand);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus randomized stimulus checked
// against a run-length reference model (define LONG_PRESS_EN to check the long-press build).
module tb_button_conditioner;
    localparam int DB   = 4;
    localparam int LONG = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic [3:0] sw_raw;
    logic       btn_pulse, btn_level, mode_valid, long_pulse;
    logic [3:0] mode_sel, mode_at_press;

    always #5 clk = ~clk;

    button_conditioner #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .btn_pulse(btn_pulse), .btn_level(btn_level), .mode_sel(mode_sel),
        .mode_valid(mode_valid), .mode_at_press(mode_at_press), .long_pulse(long_pulse)
    );

    int n_vec = 0;
    int n_bad = 0;
    int tk = 0;
    int pulse_cnt, long_cnt, first_pulse, first_long, press_tk;
    bit saw_zero_mode, valid_dropped;

    // Reference model: debounced state flips after DB+1 consecutive opposite synchronised samples.
    bit         m_d, m_armed, m_fired, p_press, p_long;
    bit         m_pulse, m_level, m_long;
    int         m_run, m_ones, m_edge, sw_run;
    logic [3:0] m_mode, m_map, sw_prev;
    bit         bq[$];
    logic [3:0] sq[$];

    function automatic bit is_valid(input logic [3:0] m);
        return (m == 4'b0001) || (m == 4'b0010) || (m == 4'b0100) || (m == 4'b1000) || (m == 4'b1111);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (tick %0d)", tag, got, exp, tk);
        end
    endtask

    task automatic model_reset();
        m_d = 0; m_armed = 0; m_fired = 0; p_press = 0; p_long = 0;
        m_pulse = 0; m_level = 0; m_long = 0;
        m_run = 0; m_ones = 0; m_edge = 0;
        m_mode = 4'd0; m_map = 4'd0;
        sw_prev = 4'd0; sw_run = 1;
        bq.delete(); sq.delete();
    endtask

    task automatic model_step(input bit b, input logic [3:0] s_raw);
        bit         s;
        logic [3:0] sw;
        bq.push_back(b);
        sq.push_back(s_raw);
        s  = 1'b0;
        sw = 4'd0;
        if (bq.size() > 2) begin
            s  = bq.pop_front();
            sw = sq.pop_front();
        end
        m_pulse = p_press;
        m_long  = p_long;
        m_level = m_d;
        if (p_press) m_map = m_mode;
        p_press = 0;
        p_long  = 0;
        if (s != m_d && (m_d || m_armed)) m_run++;
        else m_run = 0;
        if (m_run == DB + 1) begin
            m_d   = !m_d;
            m_run = 0;
            if (m_d) p_press = 1;
            else m_fired = 0;
        end
        if (s && (m_d || m_armed)) m_ones++;
        else m_ones = 0;
`ifdef LONG_PRESS_EN
        if (m_ones == LONG + 1 && !m_fired) begin
            p_long  = 1;
            m_fired = 1;
        end
`endif
        if (m_edge >= 2 && !s) m_armed = 1;
        if (sw == sw_prev) sw_run++;
        else sw_run = 1;
        sw_prev = sw;
        if (sw_run >= DB + 1) m_mode = sw;
        m_edge++;
    endtask

    task automatic tick(input bit b, input logic [3:0] s);
        btn_raw = b;
        sw_raw  = s;
        @(posedge clk);
        #1;
        model_step(b, s);
        check("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
        check("btn_level", 32'(btn_level), 32'(m_level));
        check("long_pulse", 32'(long_pulse), 32'(m_long));
        check("mode_sel", 32'(mode_sel), 32'(m_mode));
        check("mode_valid", 32'(mode_valid), 32'(is_valid(m_mode)));
        check("mode_at_press", 32'(mode_at_press), 32'(m_map));
        if (btn_pulse === 1'b1) begin
            pulse_cnt++;
            if (first_pulse < 0) first_pulse = tk;
        end
        if (long_pulse === 1'b1) begin
            long_cnt++;
            if (first_long < 0) first_long = tk;
        end
        if (mode_sel === 4'd0) saw_zero_mode = 1;
        if (mode_valid !== 1'b1) valid_dropped = 1;
        tk++;
    endtask

    task automatic clear_stats();
        pulse_cnt = 0; long_cnt = 0; first_pulse = -1; first_long = -1;
        press_tk = tk; saw_zero_mode = 0; valid_dropped = 0;
    endtask

    task automatic do_reset(input bit b, input logic [3:0] s);
        btn_raw = b;
        sw_raw  = s;
        rst_n   = 1'b0;
        #1;
        check("rst_btn_pulse", 32'(btn_pulse), 32'd0);
        check("rst_btn_level", 32'(btn_level), 32'd0);
        check("rst_mode_sel", 32'(mode_sel), 32'd0);
        check("rst_mode_valid", 32'(mode_valid), 32'd0);
        check("rst_mode_at_press", 32'(mode_at_press), 32'd0);
        check("rst_long_pulse", 32'(long_pulse), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] mode_tab [8];
        int         exp_long_cnt;
        int         exp_long_at;
        bit         b, bb;
        int         len;
        logic [3:0] sw;
        mode_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0011, 4'b0000, 4'b1010};
`ifdef LONG_PRESS_EN
        exp_long_cnt = 1;
        exp_long_at  = 23;
`else
        exp_long_cnt = 0;
        exp_long_at  = -1;
`endif
        rst_n = 1'b1; btn_raw = 1'b0; sw_raw = 4'd0;
        #2;
        do_reset(1'b0, 4'b0001);

        // Clean press: pulse exactly 7 edges after the first sampling edge, one cycle wide.
        for (int i = 0; i < 8; i++) tick(1'b0, 4'b0001);
        clear_stats();
        for (int i = 0; i < 10; i++) tick(1'b1, 4'b0001);
        check("clean_pulse_at", 32'(first_pulse - press_tk), 32'd7);
        check("clean_pulse_count", 32'(pulse_cnt), 32'd1);
        check("clean_level", 32'(btn_level), 32'd1);
        check("clean_map", 32'(mode_at_press), 32'b0001);
        for (int i = 0; i < 10; i++) tick(1'b0, 4'b0001);

        // Press bounce gives nothing; release bounce while held gives no second pulse.
        clear_stats();
        tick(1'b1, 4'b0001); tick(1'b0, 4'b0001); tick(1'b1, 4'b0001); tick(1'b0, 4'b0001);
        for (int i = 0; i < 10; i++) tick(1'b0, 4'b0001);
        check("bounce_no_pulse", 32'(pulse_cnt), 32'd0);
        for (int i = 0; i < 10; i++) tick(1'b1, 4'b0001);
        tick(1'b0, 4'b0001); tick(1'b1, 4'b0001);
        for (int i = 0; i < 8; i++) tick(1'b1, 4'b0001);
        check("release_bounce_one_pulse", 32'(pulse_cnt), 32'd1);
        for (int i = 0; i < 10; i++) tick(1'b0, 4'b0001);

        // Button held through reset release.
        do_reset(1'b1, 4'b0001);
        clear_stats();
        for (int i = 0; i < 12; i++) tick(1'b1, 4'b0001);
        check("held_reset_no_pulse", 32'(pulse_cnt), 32'd0);
        for (int i = 0; i < 6; i++) tick(1'b0, 4'b0001);
        for (int i = 0; i < 10; i++) tick(1'b1, 4'b0001);
        check("held_reset_one_pulse", 32'(pulse_cnt), 32'd1);
        for (int i = 0; i < 10; i++) tick(1'b0, 4'b0001);

        // Switch glitch never reaches mode_sel.
        clear_stats();
        tick(1'b0, 4'b0000); tick(1'b0, 4'b0000);
        for (int i = 0; i < 10; i++) tick(1'b0, 4'b1000);
        check("sw_no_0000", 32'(saw_zero_mode), 32'd0);
        check("sw_valid_held", 32'(valid_dropped), 32'd0);
        check("sw_final", 32'(mode_sel), 32'b1000);
        for (int i = 0; i < 8; i++) tick(1'b0, 4'b0011);
        check("sw_invalid", 32'(mode_valid), 32'd0);

        // Reset during PRESS_WAIT, button stays held afterwards.
        for (int i = 0; i < 8; i++) tick(1'b0, 4'b0100);
        for (int i = 0; i < 3; i++) tick(1'b1, 4'b0100);
        do_reset(1'b1, 4'b0100);
        clear_stats();
        for (int i = 0; i < 12; i++) tick(1'b1, 4'b0100);
        check("midpress_no_pulse", 32'(pulse_cnt), 32'd0);
        for (int i = 0; i < 10; i++) tick(1'b0, 4'b0100);

        // Long hold.
        clear_stats();
        for (int i = 0; i < 30; i++) tick(1'b1, 4'b0100);
        check("long_btn_pulse_at", 32'(first_pulse - press_tk), 32'd7);
        check("long_count", 32'(long_cnt), 32'(exp_long_cnt));
        check("long_at", 32'((first_long < 0) ? -1 : first_long - press_tk), 32'(exp_long_at));
        for (int i = 0; i < 10; i++) tick(1'b0, 4'b0100);

        // Randomized segments with bounce, switch glitches and occasional resets.
        sw = 4'b0001;
        for (int seg = 0; seg < 80; seg++) begin
            b   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 35)) : int'($urandom_range(1, 8));
            if ($urandom_range(0, 2) == 0) sw = mode_tab[$urandom_range(0, 7)];
            for (int i = 0; i < len; i++) begin
                bb = b;
                if ($urandom_range(0, 9) == 0) bb = !b;
                tick(bb, ($urandom_range(0, 7) == 0) ? 4'($urandom) : sw);
            end
            if ($urandom_range(0, 24) == 0) do_reset(1'($urandom_range(0, 1)), sw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
